// File: rtl/rand_pkg.sv
// Shared types and helpers for the bounded random sampler.
//   rand_bounded_state_t : FSM state encoding (IDLE, CALC, RUN)
//   mask_for()           : smallest all-ones mask covering every value below bound
package rand_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RUN} rand_bounded_state_t;

    // Returns 2**ceil(log2(bound)) - 1. bound=1 yields 0, so the only
    // candidate is 0. The bit-smear fills every bit below the MSB of bound-1.
    function automatic logic [31:0] mask_for(input logic [31:0] bound);
        logic [31:0] m;
        m = bound - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/rand_bounded.sv
// rand_bounded: turns a raw PRNG word stream into uniform integers in
// [0, bound) using mask-and-reject sampling, with a valid/ready output.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rand_in/rand_valid    PRNG word and its valid flag (dropped if !rand_ready)
//   rand_ready            block consumes rand_in this cycle
//   bound/bound_load      exclusive upper limit (1..2**OUT_WIDTH), latched on pulse
//   bound_err             last bound_load carried bound=0
//   out_data/out_valid    sample and its valid flag
//   out_ready             sink accepts out_data
//   reject_count          saturating count of rejected candidates
//
// Optional feature: define RAND_BOUNDED_REJECT_COUNT_EN to build the reject
// counter; otherwise reject_count is tied to 0.
module rand_bounded
    import rand_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     rand_in,
    input  logic                 rand_valid,
    output logic                 rand_ready,
    input  logic [OUT_WIDTH:0]   bound,
    input  logic                 bound_load,
    output logic                 bound_err,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          reject_count
);

    rand_bounded_state_t  state;
    logic [OUT_WIDTH:0]   bound_q;
    logic [OUT_WIDTH-1:0] mask_q;
    logic [OUT_WIDTH-1:0] cand;
    logic                 accept;
    logic                 take;

    // Ready only in RUN and only when the output slot is empty or being drained.
    assign rand_ready = (state == RUN) && (!out_valid || out_ready);

    // A bound_load overrides any take on the same cycle.
    assign take   = rand_valid && rand_ready && !bound_load;
    assign cand   = rand_in[OUT_WIDTH-1:0] & mask_q;
    assign accept = ({1'b0, cand} < bound_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            bound_err <= 1'b0;
            bound_q   <= '0;
            mask_q    <= '0;
        end else if (bound_load) begin
            // Any pending sample is discarded on reload.
            out_valid <= 1'b0;
            if (bound != '0) begin
                bound_q   <= bound;
                bound_err <= 1'b0;
                state     <= CALC;
            end else begin
                bound_err <= 1'b1;
                state     <= IDLE;
            end
        end else begin
            case (state)
                IDLE: ;
                CALC: begin
                    mask_q <= OUT_WIDTH'(mask_for(32'(bound_q)));
                    state  <= RUN;
                end
                RUN: begin
                    if (take && accept) begin
                        out_data  <= cand;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        // Held sample popped (or slot already empty) with nothing new.
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAND_BOUNDED_REJECT_COUNT_EN
    logic [15:0] reject_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reject_q <= '0;
        end else if (bound_load) begin
            if (bound != '0) begin
                reject_q <= '0;
            end
        end else if (take && !accept && (reject_q != 16'hFFFF)) begin
            reject_q <= reject_q + 16'd1;
        end
    end

    assign reject_count = reject_q;
`else
    assign reject_count = 16'd0;
`endif

endmodule

// File: tb/tb_rand_bounded.sv
// Self-checking bench for rand_bounded (WIDTH=OUT_WIDTH=4). A behavioural
// reference model predicts handshake and state; accepted samples go onto a
// scoreboard queue and are compared when the DUT presents them.
module tb_rand_bounded;

    logic        clk;
    logic        reset;
    logic [3:0]  rand_in;
    logic        rand_valid;
    logic        rand_ready;
    logic [4:0]  bound;
    logic        bound_load;
    logic        bound_err;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] reject_count;

    rand_bounded #(.WIDTH(4), .OUT_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rand_in      (rand_in),
        .rand_valid   (rand_valid),
        .rand_ready   (rand_ready),
        .bound        (bound),
        .bound_load   (bound_load),
        .bound_err    (bound_err),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reject_count (reject_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0=IDLE 1=CALC 2=RUN
    int         m_state;
    bit         m_valid;
    bit         m_err;
    int         m_bound;
    int         m_mask;
    int         m_rc;
    logic [3:0] sb[$];
    bit         popped;
    logic [3:0] popped_val;
    int         n_pops;

    typedef struct {
        logic       rv;
        logic [3:0] rin;
        logic       ordy;
        logic       bl;
        logic [4:0] bnd;
        logic       ev;
        logic [3:0] ed;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_mask(input int b);
        int m;
        m = 0;
        while ((m + 1) < b) m = m * 2 + 1;
        return m;
    endfunction

    function automatic int exp_rc();
`ifdef RAND_BOUNDED_REJECT_COUNT_EN
        return m_rc;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_valid = 0; m_err = 0;
        m_bound = 0; m_mask = 0; m_rc = 0;
        sb.delete();
    endtask

    // Called at posedge+1; drives one cycle, checks pre-edge outputs,
    // advances the model and returns at the next posedge+1.
    task automatic cycle(input logic rv, input logic [3:0] rin, input logic ordy,
                         input logic bl, input logic [4:0] bnd);
        bit         m_ready;
        bit         m_take;
        int         cand;
        rand_valid = rv; rand_in = rin; out_ready = ordy;
        bound_load = bl; bound = bnd;
        popped = 0;
        #2;
        m_ready = (m_state == 2) && (!m_valid || ordy);
        check("rand_ready", rand_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        check("bound_err", bound_err, m_err);
        if (m_valid && sb.size() > 0) begin
            check("out_data", out_data, sb[0]);
            if (ordy) begin
                popped = 1;
                popped_val = sb.pop_front();
                n_pops++;
            end
        end
        m_take = rv && m_ready && !bl;
        if (bl) begin
            m_valid = 0;
            sb.delete();
            if (bnd != 0) begin
                m_bound = bnd; m_err = 0; m_state = 1; m_rc = 0;
            end else begin
                m_err = 1; m_state = 0;
            end
        end else if (m_state == 1) begin
            m_mask = ref_mask(m_bound);
            m_state = 2;
        end else if (m_state == 2) begin
            cand = int'(rin) & m_mask;
            if (m_take && cand < m_bound) begin
                sb.push_back(4'(cand));
                m_valid = 1;
            end else begin
                if (m_take && m_rc < 65535) m_rc++;
                if (ordy) m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    logic [3:0] x;
    int budget;

    initial begin
        rand_valid = 0; rand_in = 0; out_ready = 0; bound_load = 0; bound = 0;
        n_pops = 0;
        model_reset();

        // 1: reset for two cycles
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_rand_ready", rand_ready, 0);
        check("rst_bound_err", bound_err, 0);
        check("rst_reject_count", reject_count, 0);

        // 2: reject sampling with bound=10 (mask 15)
        vecs[0] = '{0, 4'd0,  1, 1, 5'd10, 0, 4'd0};
        vecs[1] = '{0, 4'd0,  1, 0, 5'd0,  0, 4'd0};
        vecs[2] = '{1, 4'd3,  1, 0, 5'd0,  1, 4'd3};
        vecs[3] = '{1, 4'd12, 1, 0, 5'd0,  0, 4'd0};
        vecs[4] = '{1, 4'd15, 1, 0, 5'd0,  0, 4'd0};
        vecs[5] = '{1, 4'd9,  1, 0, 5'd0,  1, 4'd9};
        vecs[6] = '{0, 4'd0,  1, 0, 5'd0,  0, 4'd0};
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].rv, vecs[i].rin, vecs[i].ordy, vecs[i].bl, vecs[i].bnd);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
        end
        check("reject_count_t2", reject_count, exp_rc());
`ifdef RAND_BOUNDED_REJECT_COUNT_EN
        check("reject_count_is_2", reject_count, 2);
`endif

        // 3: backpressure holds 3, then 5 follows with no bubble
        cycle(1, 4'd3, 1, 0, 0);
        check("bp_first", out_data, 3);
        cycle(1, 4'd5, 0, 0, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, 3);
        cycle(1, 4'd5, 0, 0, 0);
        check("bp_hold2_data", out_data, 3);
        cycle(1, 4'd5, 1, 0, 0);
        check("bp_next_valid", out_valid, 1);
        check("bp_next_data", out_data, 5);

        // 1b: asynchronous reset while a sample is held
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", rand_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check("async_rst_rc", reject_count, 0);

        // 4: bound=16 passes everything unchanged
        cycle(0, 0, 1, 1, 5'd16);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 4'(i), 1, 0, 0);
            check($sformatf("b16_data%0d", i), out_data, i);
            check($sformatf("b16_valid%0d", i), out_valid, 1);
        end
        // bound=1 forces every output to 0
        cycle(0, 0, 1, 1, 5'd1);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 4'($urandom_range(0, 15)), 1, 0, 0);
            check("b1_valid", out_valid, 1);
            check("b1_data", out_data, 0);
        end
        // bound=5 (mask 7): 13 -> 5, rejected
        cycle(0, 0, 1, 1, 5'd5);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 4'd13, 1, 0, 0);
        check("b5_reject", out_valid, 0);
        check("reject_count_t4", reject_count, exp_rc());

        // 5: reload while stalled discards the held sample
        cycle(0, 0, 1, 1, 5'd3);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 4'd2, 0, 0, 0);
        check("rl_held", out_valid, 1);
        cycle(1, 4'd1, 0, 1, 5'd3);
        check("rl_dropped", out_valid, 0);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 4'($urandom_range(0, 15)), 1, 0, 0);
            if (popped) check("rl_lt3", int'(popped_val < 4'd3), 1);
        end
        cycle(0, 0, 1, 1, 5'd0);
        check("err_set", bound_err, 1);
        check("err_ready", rand_ready, 0);
        cycle(1, 4'd1, 1, 0, 0);
        check("err_idle_valid", out_valid, 0);

        // 6: free-running xorshift, bound=11, random backpressure
        cycle(0, 0, 1, 1, 5'd11);
        cycle(0, 0, 1, 0, 0);
        x = 4'd9;
        n_pops = 0;
        budget = 0;
        while (n_pops < 48 && budget < 3000) begin
            cycle(1, x, 1'($urandom_range(0, 1)), 0, 0);
            if (popped) check("xs_lt11", int'(popped_val < 4'd11), 1);
            x = x ^ (x << 1);
            x = x ^ (x >> 3);
            x = x ^ (x << 2);
            budget++;
        end
        check("xs_budget", int'(n_pops >= 48), 1);
        check("reject_count_t6", reject_count, exp_rc());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
